// File: rtl/ds_operand_stage.sv
// ds_operand_stage
//   Single-entry operand-resolve stage. Holds one decoded instruction,
//   drives its source addresses to the register file and resolves each
//   operand from the bypass network (channel 0 = youngest, highest priority)
//   or from the register file. Stalls while a selected producer is not ready.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_allowin        upstream handshake
//   in_payload, in_rs1/2(_en)  decoded instruction and source fields
//   rf_raddr1/2, rf_rdata1/2   register-file read port (combinational data)
//   byp_valid/ready/addr/data  bypass channels, packed NUM_BYP wide
//   flush                      kill the held instruction
//   out_valid/out_allowin      downstream handshake
//   out_payload, out_op1/2     held payload and resolved operands
//   stall_clr, stall_cnt       stall-cycle counter
//
// Configuration
//   DS_STALL_CNT_EN  defined: saturating stall counter present.
//                    undefined: stall_cnt is constant 0.
module ds_operand_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RADDR_W   = 5,
  parameter int unsigned NUM_BYP   = 3,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_allowin,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [RADDR_W-1:0]           in_rs1,
  input  logic [RADDR_W-1:0]           in_rs2,
  input  logic                         in_rs1_en,
  input  logic                         in_rs2_en,
  output logic [RADDR_W-1:0]           rf_raddr1,
  output logic [RADDR_W-1:0]           rf_raddr2,
  input  logic [DATA_W-1:0]            rf_rdata1,
  input  logic [DATA_W-1:0]            rf_rdata2,
  input  logic [NUM_BYP-1:0]           byp_valid,
  input  logic [NUM_BYP-1:0]           byp_ready,
  input  logic [NUM_BYP*RADDR_W-1:0]   byp_addr,
  input  logic [NUM_BYP*DATA_W-1:0]    byp_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_allowin,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [DATA_W-1:0]            out_op1,
  output logic [DATA_W-1:0]            out_op2,
  input  logic                         stall_clr,
  output logic [CNT_W-1:0]             stall_cnt
);

  logic                 ds_valid_q, ds_valid_d;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [RADDR_W-1:0]   rs1_q, rs2_q;
  logic                 rs1_en_q, rs2_en_q;
  logic                 ds_go;
  logic                 stall1, stall2;
  logic                 load;

  // Returns {stall, operand}. The first matching channel wins even if it is
  // not ready, so an older ready producer never masks a younger pending one.
  function automatic logic [DATA_W:0] resolve(
    input logic                       en,
    input logic [RADDR_W-1:0]         rs,
    input logic [DATA_W-1:0]          rf,
    input logic [NUM_BYP-1:0]         bv,
    input logic [NUM_BYP-1:0]         br,
    input logic [NUM_BYP*RADDR_W-1:0] ba,
    input logic [NUM_BYP*DATA_W-1:0]  bd
  );
    logic             found;
    logic [DATA_W:0]  r;
    found = 1'b0;
    r     = {1'b0, rf};
    if (!en || rs == '0) begin
      r = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BYP; i++) begin
        if (!found && bv[i] && ba[i*RADDR_W +: RADDR_W] == rs) begin
          found = 1'b1;
          r     = {~br[i], bd[i*DATA_W +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    {stall1, out_op1} = resolve(rs1_en_q, rs1_q, rf_rdata1,
                                byp_valid, byp_ready, byp_addr, byp_data);
    {stall2, out_op2} = resolve(rs2_en_q, rs2_q, rf_rdata2,
                                byp_valid, byp_ready, byp_addr, byp_data);
    ds_go      = !(stall1 || stall2);
    in_allowin = !ds_valid_q || (ds_go && out_allowin);
    out_valid  = ds_valid_q && ds_go;
    load       = in_valid && in_allowin && !flush;
    ds_valid_d = ds_valid_q;
    if (flush)           ds_valid_d = 1'b0;
    else if (in_allowin) ds_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) ds_valid_q <= 1'b0;
    else       ds_valid_q <= ds_valid_d;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      payload_q <= in_payload;
      rs1_q     <= in_rs1;
      rs2_q     <= in_rs2;
      rs1_en_q  <= in_rs1_en;
      rs2_en_q  <= in_rs2_en;
    end
  end

  assign rf_raddr1   = rs1_q;
  assign rf_raddr2   = rs2_q;
  assign out_payload = payload_q;

`ifdef DS_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)
      stall_cnt_d = '0;
    else if (ds_valid_q && !ds_go && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr;
  assign stall_cnt        = '0;
`endif

endmodule

// File: doc/ds_operand_stage.md
DS_OPERAND_STAGE -- requirements
Module: ds_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand and bypass data width.
REQ-002 Parameter RADDR_W, default 5, register address width.
REQ-003 Parameter NUM_BYP, default 3, number of bypass channels; index 0 is the youngest producer and has the highest priority.
REQ-004 Parameter PAYLOAD_W, default 64, width of the opaque decoded-instruction payload.
REQ-005 Parameter CNT_W, default 16, stall counter width.
REQ-006 clk  input  1  clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  upstream instruction valid.
REQ-009 in_allowin  output  1  stage accepts the upstream instruction this cycle.
REQ-010 in_payload  input  PAYLOAD_W  decoded fields.
REQ-011 in_rs1, in_rs2  input  RADDR_W each  source register addresses.
REQ-012 in_rs1_en, in_rs2_en  input  1 each  source actually read.
REQ-013 rf_raddr1, rf_raddr2  output  RADDR_W each  registered rs1/rs2 driven to the register file.
REQ-014 rf_rdata1, rf_rdata2  input  DATA_W each  combinational register-file read data.
REQ-015 byp_valid  input  NUM_BYP  channel holds a register-writing instruction.
REQ-016 byp_ready  input  NUM_BYP  channel data is final; 0 means a load is still pending.
REQ-017 byp_addr  input  NUM_BYP*RADDR_W  destination register per channel.
REQ-018 byp_data  input  NUM_BYP*DATA_W  result per channel.
REQ-019 flush  input  1  kill the held instruction (taken branch).
REQ-020 out_valid  output  1  operands resolved; instruction offered downstream.
REQ-021 out_allowin  input  1  downstream accepts.
REQ-022 out_payload  output  PAYLOAD_W  held payload.
REQ-023 out_op1, out_op2  output  DATA_W each  resolved operands.
REQ-024 stall_clr  input  1  clear the stall counter.
REQ-025 stall_cnt  output  CNT_W  count of stalled cycles.

Function
REQ-026 The stage SHALL hold one instruction in a valid register ds_valid and a payload/rs register.
REQ-027 in_allowin SHALL equal !ds_valid || (ds_go && out_allowin).
REQ-028 out_valid SHALL equal ds_valid && ds_go.
REQ-029 Payload and rs fields SHALL load on in_valid && in_allowin && !flush; ds_valid SHALL then become in_valid.
REQ-030 flush SHALL clear ds_valid at the next edge and override any simultaneous load, including one arriving in the same cycle.
REQ-031 Each enabled, nonzero source SHALL match the lowest-index channel with byp_valid=1 and an equal byp_addr.
REQ-032 The operand SHALL be that channel's byp_data; with no match it SHALL be rf_rdata.
REQ-033 Register 0 or a disabled source SHALL yield operand 0 and SHALL never stall.
REQ-034 ds_go SHALL be 0 when any enabled source's selected channel has byp_ready=0.
REQ-035 Older channels SHALL NOT be consulted once a younger channel matches.
REQ-036 While stalled, payload and rs SHALL be held, in_allowin SHALL be 0, and the operands SHALL be re-resolved every cycle.
REQ-037 Latency SHALL be 0 cycles from ds_valid to out_valid when there is no hazard; throughput SHALL be one instruction per cycle.
REQ-038 If out_valid && !out_allowin, the outputs SHALL remain stable until accepted or flushed.

Reset
REQ-039 reset SHALL clear ds_valid and stall_cnt, forcing out_valid=0 and in_allowin=1.
REQ-040 A reset asserted mid-stall SHALL discard the held instruction with no output in the following cycle.
REQ-041 The payload and rs registers need not be reset.

Configuration
REQ-042 Macro DS_STALL_CNT_EN defined: stall_cnt SHALL increment each cycle ds_valid && !ds_go, saturate at 2^CNT_W-1, and clear on stall_clr (clear wins over increment).
REQ-043 Macro DS_STALL_CNT_EN undefined: stall_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-044 Case: rs1=5, byp0 and byp2 both valid, addr 5, ready, data 0x11/0x33 -> out_op1=0x11 in the same cycle.
REQ-045 Case: rs2=7, byp1 valid, addr 7, ready=0 for 3 cycles then 1 -> out_valid=0 for 3 cycles, then op2=byp1 data, and stall_cnt=3 when the counter is enabled.
REQ-046 Case: rs1=0 with byp0 addr 0, ready=0 -> no stall, out_op1=0.
REQ-047 Case: stalled instruction with flush=1 and in_valid=1 at the same edge -> next cycle ds_valid=0, new instruction not captured.
REQ-048 Case: out_allowin=0 for 2 cycles while the instruction is valid -> outputs held, in_allowin=0, and the instruction is accepted on the third cycle.
REQ-049 Case: stall_cnt preloaded to 0xFFFF (CNT_W=16) with a continued stall -> stays 0xFFFF; stall_clr=1 -> 0.
